// File: rtl/run_step_if.sv
// run_step_if: control-unit handshake between the CPU and run_step_controller (step_mode only with RUN_STEP_SINGLE_STEP_EN).
`timescale 1ns/1ps
interface run_step_if #(parameter int FLAG_W = 4);
  logic halt_req;
  logic instr_done;
  logic [FLAG_W-1:0] alu_flags_in;
  logic cpu_en;
  logic halted;
  logic [FLAG_W-1:0] alu_flags;
  logic [7:0] halt_count;
`ifdef RUN_STEP_SINGLE_STEP_EN
  logic step_mode;
  modport master (output halt_req, instr_done, alu_flags_in, step_mode,
                  input cpu_en, halted, alu_flags, halt_count);
  modport slave (input halt_req, instr_done, alu_flags_in, step_mode,
                 output cpu_en, halted, alu_flags, halt_count);
`else
  modport master (output halt_req, instr_done, alu_flags_in,
                  input cpu_en, halted, alu_flags, halt_count);
  modport slave (input halt_req, instr_done, alu_flags_in,
                 output cpu_en, halted, alu_flags, halt_count);
`endif
endinterface

// File: rtl/run_step_controller.sv
// run_step_controller: holds the CPU after reset, halts on retired HALT, resumes on a debounced button press.
// Optional single-step (STEP state, step_mode input) enabled by RUN_STEP_SINGLE_STEP_EN.
`timescale 1ns/1ps
module run_step_controller #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int FLAG_W = 4
) (
  input logic clk_100MHz,
  input logic rst,
  input logic continue_btn,
  run_step_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  typedef enum logic [1:0] {
    INIT,
    RUN,
    HALTED
`ifdef RUN_STEP_SINGLE_STEP_EN
    , STEP
`endif
  } state_t;
  state_t state, next;
  logic [1:0] sync;
  logic deb, deb_q, flip, press, done, en_n, halted_n, en_q, halted_q;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [FLAG_W-1:0] flags;
  logic [7:0] count;
  assign flip = sync[1] != deb && deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign press = deb & ~deb_q;
  // en_n is high only in executing states, so a retire seen during the trailing enabled cycle after HALT is ignored
  assign done = bus.instr_done & en_q & en_n;
  assign bus.cpu_en = en_q;
  assign bus.halted = halted_q;
  assign bus.alu_flags = flags;
  assign bus.halt_count = count;
  always_ff @(posedge clk_100MHz)
    if (rst) state <= INIT;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      INIT: next = hold_cnt == HW'(RESET_HOLD_CYCLES - 1) ? RUN : INIT;
      RUN: next = done && bus.halt_req ? HALTED : RUN;
`ifdef RUN_STEP_SINGLE_STEP_EN
      HALTED: next = press ? (bus.step_mode ? STEP : RUN) : HALTED;
      STEP: next = done ? HALTED : STEP;
`else
      HALTED: next = press ? RUN : HALTED;
`endif
      default: next = INIT;
    endcase
  end
  always_comb begin
`ifdef RUN_STEP_SINGLE_STEP_EN
    en_n = state == RUN || state == STEP;
`else
    en_n = state == RUN;
`endif
    halted_n = state == HALTED;
  end
  always_ff @(posedge clk_100MHz)
    if (rst) begin
      sync <= '0;
      deb <= 1'b0;
      deb_q <= 1'b0;
      deb_cnt <= '0;
      hold_cnt <= '0;
      flags <= '0;
      count <= '0;
      en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      sync <= {sync[0], continue_btn};
      deb_cnt <= (sync[1] == deb || flip) ? '0 : deb_cnt + 1'b1;
      deb <= flip ? ~deb : deb;
      deb_q <= deb;
      hold_cnt <= state == INIT ? hold_cnt + 1'b1 : '0;
      if (done) flags <= bus.alu_flags_in;
      if (done && bus.halt_req && count != 8'hff) count <= count + 1'b1;
      en_q <= en_n;
      halted_q <= halted_n;
    end
endmodule

// File: tb/tb_run_step_controller.sv
// tb_run_step_controller: scoreboard bench for reset hold, halt/resume, debounce, saturation and single-step.
`timescale 1ns/1ps
module tb_run_step_controller;
  typedef struct packed {logic [3:0] flags; logic [7:0] cnt;} exp_t;
  logic clk_100MHz = 1'b0;
  logic rst = 1'b1;
  logic continue_btn = 1'b0;
  int checks = 0;
  int fails = 0;
  int cnt_m = 0;
  exp_t sb[$];
  int lat_q[$];
  run_step_if #(.FLAG_W(4)) bus();
  run_step_controller #(.DEBOUNCE_CYCLES(100), .RESET_HOLD_CYCLES(16), .FLAG_W(4)) dut (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .continue_btn(continue_btn),
    .bus(bus.slave)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk_100MHz);
    #1;
  endtask
  task automatic retire(input logic [3:0] f, input logic h);
    bus.alu_flags_in = f;
    bus.halt_req = h;
    bus.instr_done = 1'b1;
    if (h && cnt_m < 255) cnt_m++;
    sb.push_back({f, 8'(cnt_m)});
    tick;
    bus.instr_done = 1'b0;
    bus.halt_req = 1'b0;
    bus.alu_flags_in = ~f;
  endtask
  task automatic wait_halted(output int n);
    n = 0;
    while (bus.halted !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
  endtask
  task automatic press_resume(output int n);
    continue_btn = 1'b1;
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
    continue_btn = 1'b0;
    repeat (110) tick;
  endtask
  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (5) tick;
    checks++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en: got %b want 0", bus.cpu_en); end
    checks++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    checks++; if (bus.alu_flags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %h want 0", bus.alu_flags); end
    checks++; if (bus.halt_count !== 8'h0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.halt_count); end
    rst = 1'b0;
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++; if (n - 1 != 16) begin fails++; $display("FAIL reset_hold_cycles: got %0d want 16", n - 1); end
    checks++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL run_halted: got %b want 0", bus.halted); end
  endtask
  task automatic test_halt;
    exp_t e;
    int n;
    retire(4'b1001, 1'b1);
    wait_halted(n);
    e = sb.pop_front();
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_halted: got %b want 1", bus.halted); end
    checks++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL halt_cpu_en: got %b want 0", bus.cpu_en); end
    checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL halt_flags: got %b want %b", bus.alu_flags, e.flags); end
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL halt_count: got %0d want %0d", bus.halt_count, e.cnt); end
    bus.alu_flags_in = 4'b0110;
    repeat (3) tick;
    checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL halt_flags_hold: got %b want %b", bus.alu_flags, e.flags); end
    bus.instr_done = 1'b1;
    bus.halt_req = 1'b1;
    bus.alu_flags_in = 4'b1111;
    tick;
    bus.instr_done = 1'b0;
    bus.halt_req = 1'b0;
    tick;
    checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL disabled_done_flags: got %b want %b", bus.alu_flags, e.flags); end
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL disabled_done_count: got %0d want %0d", bus.halt_count, e.cnt); end
  endtask
  task automatic test_resume;
    int n;
    continue_btn = 1'b1;
    repeat (50) tick;
    continue_btn = 1'b0;
    repeat (150) tick;
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL glitch_halted: got %b want 1", bus.halted); end
    checks++; if (bus.cpu_en !== 1'b0) begin fails++; $display("FAIL glitch_cpu_en: got %b want 0", bus.cpu_en); end
    continue_btn = 1'b1;
    lat_q.push_back(104);
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    begin
      int lat = lat_q.pop_front();
      checks++; if (n < lat - 1 || n > lat + 1) begin fails++; $display("FAIL resume_latency: got %0d want %0d+-1", n, lat); end
    end
    checks++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL resume_halted: got %b want 0", bus.halted); end
    repeat (150 - n) tick;
    continue_btn = 1'b0;
    repeat (150) tick;
  endtask
  task automatic test_held;
    exp_t e;
    int n;
    retire(4'b0101, 1'b1);
    wait_halted(n);
    e = sb.pop_front();
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL held_count1: got %0d want %0d", bus.halt_count, e.cnt); end
    continue_btn = 1'b1;
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    checks++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL held_resume: got %b want 1", bus.cpu_en); end
    retire(4'b1010, 1'b1);
    repeat (800) tick;
    e = sb.pop_front();
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL held_single_press: got %b want 1", bus.halted); end
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL held_count2: got %0d want %0d", bus.halt_count, e.cnt); end
    continue_btn = 1'b0;
    repeat (150) tick;
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL release_no_press: got %b want 1", bus.halted); end
    press_resume(n);
    checks++; if (n >= 300) begin fails++; $display("FAIL held_re_press: got timeout want resume"); end
  endtask
  task automatic test_rounds;
    exp_t e;
    int n;
    logic [3:0] f;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    cnt_m = 0;
    sb.delete();
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      f = 4'($urandom);
      retire(f, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL round%0d_track: got %b want %b", i, bus.alu_flags, e.flags); end
      retire(~f ^ 4'(i), 1'b1);
      wait_halted(n);
      e = sb.pop_front();
      checks++; if (bus.halted !== 1'b1 || bus.alu_flags !== e.flags || bus.halt_count !== e.cnt) begin
        fails++;
        $display("FAIL round%0d_halt: got h=%b f=%b c=%0d want h=1 f=%b c=%0d", i, bus.halted, bus.alu_flags, bus.halt_count, e.flags, e.cnt);
      end
      press_resume(n);
      checks++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL round%0d_resume: got %b want 1", i, bus.cpu_en); end
    end
    checks++; if (bus.halt_count !== 8'd8) begin fails++; $display("FAIL rounds_count: got %0d want 8", bus.halt_count); end
  endtask
  task automatic test_reset_mid;
    exp_t e;
    retire(4'b1111, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL mid_pre_flags: got %b want %b", bus.alu_flags, e.flags); end
    continue_btn = 1'b1;
    repeat (40) tick;
    rst = 1'b1;
    tick;
    checks++; if (bus.cpu_en !== 1'b0 || bus.halted !== 1'b0) begin fails++; $display("FAIL mid_reset_ctl: got en=%b h=%b want 0 0", bus.cpu_en, bus.halted); end
    checks++; if (bus.alu_flags !== 4'h0 || bus.halt_count !== 8'h0) begin fails++; $display("FAIL mid_reset_regs: got f=%h c=%0d want 0 0", bus.alu_flags, bus.halt_count); end
    rst = 1'b0;
    continue_btn = 1'b0;
    cnt_m = 0;
    repeat (300) tick;
    checks++; if (bus.cpu_en !== 1'b1 || bus.halted !== 1'b0) begin fails++; $display("FAIL mid_after: got en=%b h=%b want 1 0", bus.cpu_en, bus.halted); end
    checks++; if (bus.halt_count !== 8'h0) begin fails++; $display("FAIL mid_after_count: got %0d want 0", bus.halt_count); end
  endtask
`ifdef RUN_STEP_SINGLE_STEP_EN
  task automatic test_step;
    exp_t e;
    int n;
    retire(4'b0001, 1'b1);
    wait_halted(n);
    e = sb.pop_front();
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL step_pre_count: got %0d want %0d", bus.halt_count, e.cnt); end
    bus.step_mode = 1'b1;
    continue_btn = 1'b1;
    n = 0;
    while (bus.cpu_en !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
    continue_btn = 1'b0;
    checks++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL step_enter: got %b want 1", bus.cpu_en); end
    retire(4'b0011, 1'b0);
    tick;
    bus.alu_flags_in = 4'b0101;
    bus.instr_done = 1'b1;
    tick;
    bus.instr_done = 1'b0;
    tick;
    bus.alu_flags_in = 4'b0111;
    bus.instr_done = 1'b1;
    tick;
    bus.instr_done = 1'b0;
    wait_halted(n);
    e = sb.pop_front();
    checks++; if (bus.halted !== 1'b1 || bus.cpu_en !== 1'b0) begin fails++; $display("FAIL step_rehalt: got h=%b en=%b want 1 0", bus.halted, bus.cpu_en); end
    checks++; if (bus.alu_flags !== e.flags) begin fails++; $display("FAIL step_flags: got %b want %b", bus.alu_flags, e.flags); end
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL step_count: got %0d want %0d", bus.halt_count, e.cnt); end
    bus.step_mode = 1'b0;
    repeat (110) tick;
    press_resume(n);
    checks++; if (bus.cpu_en !== 1'b1) begin fails++; $display("FAIL step_run_resume: got %b want 1", bus.cpu_en); end
  endtask
`endif
  task automatic test_saturate;
    exp_t e;
    int n;
    int bad = 0;
    while (cnt_m < 255 && bad == 0) begin
      retire(4'(cnt_m), 1'b1);
      wait_halted(n);
      e = sb.pop_front();
      if (n >= 10 || bus.halt_count !== e.cnt) bad++;
      press_resume(n);
      if (n >= 300) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL sat_rounds: got %0d bad rounds at count %0d want 0", bad, bus.halt_count); end
    retire(4'hA, 1'b1);
    wait_halted(n);
    e = sb.pop_front();
    checks++; if (bus.halt_count !== e.cnt) begin fails++; $display("FAIL sat_count: got %0d want %0d", bus.halt_count, e.cnt); end
  endtask
  initial begin
    bus.halt_req = 1'b0;
    bus.instr_done = 1'b0;
    bus.alu_flags_in = 4'h0;
`ifdef RUN_STEP_SINGLE_STEP_EN
    bus.step_mode = 1'b0;
`endif
    test_reset;
    test_halt;
    test_resume;
    test_held;
    test_rounds;
    test_reset_mid;
`ifdef RUN_STEP_SINGLE_STEP_EN
    test_step;
`endif
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
